// File: rtl/bcd2hex_4_if.sv
// ----------------------------------------------------------------------------
// bcd2hex_4_if
// Request/result bundle for the 4-digit BCD-to-binary converter.
//
// Signals:
//   start   request, converter acts on its rising edge
//   bcd_a   thousands digit
//   bcd_b   hundreds digit
//   bcd_c   tens digit
//   bcd_d   ones digit
//   dout    14-bit binary result (0..9999)
//   done    one-cycle pulse when dout/err update
//   busy    conversion in progress
//   err     last conversion saw a digit > 9
//
// Modports:
//   master  requester side (entry logic / testbench)
//   slave   converter side
// ----------------------------------------------------------------------------
interface bcd2hex_4_if;
   logic        start;
   logic [3:0]  bcd_a;
   logic [3:0]  bcd_b;
   logic [3:0]  bcd_c;
   logic [3:0]  bcd_d;
   logic [13:0] dout;
   logic        done;
   logic        busy;
   logic        err;

   modport master (
      output start,
      output bcd_a,
      output bcd_b,
      output bcd_c,
      output bcd_d,
      input  dout,
      input  done,
      input  busy,
      input  err
   );

   modport slave (
      input  start,
      input  bcd_a,
      input  bcd_b,
      input  bcd_c,
      input  bcd_d,
      output dout,
      output done,
      output busy,
      output err
   );
endinterface

// File: rtl/bcd2hex_4.sv
// ----------------------------------------------------------------------------
// bcd2hex_4
// Sequential 4-digit packed-BCD to 14-bit binary converter. A rising edge of
// start in idle latches the four digits, then four clocks of
// acc = acc*10 + digit run in order thousands..ones, and a finish cycle
// publishes the result with a one-cycle done pulse. A digit above 9 flags err
// and forces the result to zero; the accumulation still runs so the timing
// never depends on the data.
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous reset, active-high
//   bus   bcd2hex_4_if.slave: start, bcd_a..bcd_d in; dout, done, busy, err out
// ----------------------------------------------------------------------------
module bcd2hex_4 (
   input  logic           clk,
   input  logic           rst,
   bcd2hex_4_if.slave     bus
);

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StConv   = 2'd1,
      StFinish = 2'd2
   } state_e;

   state_e      state_q, state_d;

   logic        start_q;
   logic [13:0] acc_q, acc_d;
   logic [1:0]  idx_q, idx_d;
   logic [3:0]  dig_a_q, dig_a_d;
   logic [3:0]  dig_b_q, dig_b_d;
   logic [3:0]  dig_c_q, dig_c_d;
   logic [3:0]  dig_d_q, dig_d_d;
   logic        err_pend_q, err_pend_d;
   logic [13:0] dout_q, dout_d;
   logic        done_q, done_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;

   logic        start_rise;
   logic        accept;
   logic        any_invalid;
   logic [3:0]  dig_sel;
   logic [13:0] acc_x10;

   // Edge detect; a start arriving outside idle is dropped, not queued.
   assign start_rise  = bus.start & ~start_q;
   assign accept      = start_rise && (state_q == StIdle);

   assign any_invalid = (bus.bcd_a > 4'd9) || (bus.bcd_b > 4'd9) ||
                        (bus.bcd_c > 4'd9) || (bus.bcd_d > 4'd9);

   // acc*10 as shift-and-add, truncated to 14 bits. Only invalid digits can
   // push past 9999, and that result is discarded anyway.
   assign acc_x10 = {acc_q[10:0], 3'b000} + {acc_q[12:0], 1'b0};

   always_comb begin
      dig_sel = 4'd0;
      unique case (idx_q)
         2'd0:    dig_sel = dig_a_q;
         2'd1:    dig_sel = dig_b_q;
         2'd2:    dig_sel = dig_c_q;
         2'd3:    dig_sel = dig_d_q;
         default: dig_sel = 4'd0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register and all datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         start_q    <= 1'b0;
         acc_q      <= 14'd0;
         idx_q      <= 2'd0;
         dig_a_q    <= 4'd0;
         dig_b_q    <= 4'd0;
         dig_c_q    <= 4'd0;
         dig_d_q    <= 4'd0;
         err_pend_q <= 1'b0;
         dout_q     <= 14'd0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         start_q    <= bus.start;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         dig_a_q    <= dig_a_d;
         dig_b_q    <= dig_b_d;
         dig_c_q    <= dig_c_d;
         dig_d_q    <= dig_d_d;
         err_pend_q <= err_pend_d;
         dout_q     <= dout_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StConv;
            end
         end
         StConv: begin
            if (idx_q == 2'd3) begin
               state_d = StFinish;
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath / output next values
   // ---------------------------------------------------------------------------
   always_comb begin
      acc_d      = acc_q;
      idx_d      = idx_q;
      dig_a_d    = dig_a_q;
      dig_b_d    = dig_b_q;
      dig_c_d    = dig_c_q;
      dig_d_d    = dig_d_q;
      err_pend_d = err_pend_q;
      dout_d     = dout_q;
      err_d      = err_q;
      // done is a pure one-cycle pulse out of the finish state.
      done_d     = 1'b0;
      busy_d     = busy_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               dig_a_d    = bus.bcd_a;
               dig_b_d    = bus.bcd_b;
               dig_c_d    = bus.bcd_c;
               dig_d_d    = bus.bcd_d;
               err_pend_d = any_invalid;
               acc_d      = 14'd0;
               idx_d      = 2'd0;
               busy_d     = 1'b1;
            end
         end
         StConv: begin
            acc_d = acc_x10 + {10'd0, dig_sel};
            idx_d = idx_q + 2'd1;
         end
         StFinish: begin
            dout_d = err_pend_q ? 14'd0 : acc_q;
            err_d  = err_pend_q;
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   assign bus.dout = dout_q;
   assign bus.done = done_q;
   assign bus.busy = busy_q;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd2hex_4.sv
// ----------------------------------------------------------------------------
// tb_bcd2hex_4
// Self-checking bench for bcd2hex_4: directed scenarios plus randomized digit
// sets compared against a decimal-arithmetic reference.
// ----------------------------------------------------------------------------
module tb_bcd2hex_4;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   int   done_cnt;

   bcd2hex_4_if bus ();

   bcd2hex_4 u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every done pulse seen, sampled away from the rising edge.
   always @(negedge clk) begin
      if (bus.done === 1'b1) done_cnt = done_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests = n_tests + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Reference: plain decimal weighting; any non-decimal digit zeroes the result.
   function automatic logic [31:0] ref_val(input int a, input int b, input int c, input int d);
      if (a > 9 || b > 9 || c > 9 || d > 9) return 32'd0;
      return 32'(a * 1000 + b * 100 + c * 10 + d);
   endfunction

   function automatic logic ref_err(input int a, input int b, input int c, input int d);
      return (a > 9 || b > 9 || c > 9 || d > 9);
   endfunction

   task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                             input logic [3:0] c, input logic [3:0] d);
      bus.bcd_a = a;
      bus.bcd_b = b;
      bus.bcd_c = c;
      bus.bcd_d = d;
   endtask

   // Full conversion with latency, busy and done-width checks.
   task automatic do_conv(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
      int lat;
      int busy_ok;
      int cnt0;
      logic [31:0] exp_v;
      logic        exp_e;
      exp_v = ref_val(int'(a), int'(b), int'(c), int'(d));
      exp_e = ref_err(int'(a), int'(b), int'(c), int'(d));
      @(posedge clk); #1;
      set_digits(a, b, c, d);
      bus.start = 1'b1;
      @(posedge clk); #1;         // accepting edge E0
      bus.start = 1'b0;
      set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      cnt0    = done_cnt;
      lat     = 0;
      busy_ok = 1;
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_ok = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.done === 1'b1) lat = k;
         else if (bus.busy !== 1'b1) busy_ok = 0;
      end
      check({tag, " latency"}, 32'(lat), 32'd5);
      check({tag, " busy"}, 32'(busy_ok), 32'd1);
      check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
      check({tag, " dout"}, {18'd0, bus.dout}, exp_v);
      check({tag, " err"}, {31'd0, bus.err}, {31'd0, exp_e});
      @(negedge clk);
      check({tag, " done_width"}, {31'd0, bus.done}, 32'd0);
      check({tag, " done_count"}, 32'(done_cnt - cnt0), 32'd1);
   endtask

   initial begin
      int cnt0;
      int a, b, c, d;
      n_tests  = 0;
      n_fail   = 0;
      done_cnt = 0;
      rst      = 1'b1;
      bus.start = 1'b0;
      set_digits(4'd0, 4'd0, 4'd0, 4'd0);

      // 1: reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst dout", {18'd0, bus.dout}, 32'd0);
      check("rst done", {31'd0, bus.done}, 32'd0);
      check("rst busy", {31'd0, bus.busy}, 32'd0);
      check("rst err", {31'd0, bus.err}, 32'd0);

      // 2-4: directed values
      do_conv("c1234", 4'd1, 4'd2, 4'd3, 4'd4);
      do_conv("c9999", 4'd9, 4'd9, 4'd9, 4'd9);
      do_conv("c0000", 4'd0, 4'd0, 4'd0, 4'd0);
      do_conv("cinv", 4'd5, 4'hA, 4'd0, 4'd7);
      do_conv("c0042", 4'd0, 4'd0, 4'd4, 4'd2);

      // 5: digits changed and start re-pulsed at E2 and E5 must be ignored
      @(posedge clk); #1;
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      bus.start = 1'b1;
      cnt0 = done_cnt;
      @(posedge clk); #1;         // E0
      bus.start = 1'b0;
      @(posedge clk); #1;         // after E1
      set_digits(4'd9, 4'd9, 4'd9, 4'd9);
      bus.start = 1'b1;
      @(posedge clk); #1;         // after E2
      bus.start = 1'b0;
      @(posedge clk);             // E3
      @(posedge clk); #1;         // after E4
      bus.start = 1'b1;
      @(posedge clk); #1;         // after E5
      bus.start = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      check("ign done_count", 32'(done_cnt - cnt0), 32'd1);
      check("ign dout", {18'd0, bus.dout}, 32'd1234);
      check("ign busy", {31'd0, bus.busy}, 32'd0);

      // 6: reset at E3 aborts without done
      @(posedge clk); #1;
      set_digits(4'd8, 4'd8, 4'd8, 4'd8);
      bus.start = 1'b1;
      cnt0 = done_cnt;
      @(posedge clk); #1;         // E0
      bus.start = 1'b0;
      @(posedge clk);             // E1
      @(posedge clk); #1;         // after E2
      rst = 1'b1;
      @(posedge clk); #1;         // E3 sampled reset
      rst = 1'b0;
      @(negedge clk);
      check("abort busy", {31'd0, bus.busy}, 32'd0);
      check("abort dout", {18'd0, bus.dout}, 32'd0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("abort done_count", 32'(done_cnt - cnt0), 32'd0);
      check("abort busy_late", {31'd0, bus.busy}, 32'd0);
      do_conv("c0007", 4'd0, 4'd0, 4'd0, 4'd7);

      // Randomized: mostly decimal digits, occasionally invalid ones.
      for (int i = 0; i < 40; i++) begin
         a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
         b = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
         c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
         d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
         do_conv($sformatf("rnd%0d", i), 4'(a), 4'(b), 4'(c), 4'(d));
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
